// File: rtl/pokey_poly_gen.sv
// POKEY polynomial noise generators: 4/5/9/17-bit XNOR LFSRs stepped by a 1.79 MHz strobe.
// Feeds the audio noise filters and the RANDOM register.
module pokey_poly_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       init,
    input  logic       poly9_select,
    output logic       noise_4,
    output logic       noise_5,
    output logic       noise_large,
    output logic [7:0] rand_out,
    output logic       noise_step
);

    logic [3:0]  p4;
    logic [4:0]  p5;
    logic [8:0]  p9;
    logic [16:0] p17;

    logic fb4, fb5, fb9, fb17;

    // XNOR feedback keeps all-zero as a legal state, so reset and init can simply clear.
    assign fb4  = ~(p4[3]   ^ p4[2]);
    assign fb5  = ~(p5[4]   ^ p5[2]);
    assign fb9  = ~(p9[8]   ^ p9[4]);
    assign fb17 = ~(p17[16] ^ p17[13]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p4         <= '0;
            p5         <= '0;
            p9         <= '0;
            p17        <= '0;
            noise_step <= 1'b0;
        end else if (init) begin
            p4         <= '0;
            p5         <= '0;
            p9         <= '0;
            p17        <= '0;
            noise_step <= 1'b0;
        end else if (enable) begin
            p4         <= {p4[2:0],   fb4};
            p5         <= {p5[3:0],   fb5};
            p9         <= {p9[7:0],   fb9};
            p17        <= {p17[15:0], fb17};
            noise_step <= 1'b1;
        end else begin
            noise_step <= 1'b0;
        end
    end

    // Both long polynomials always run; the select only steers which one is seen.
    assign noise_4     = p4[3];
    assign noise_5     = p5[4];
    assign noise_large = poly9_select ? p9[8]   : p17[16];
    assign rand_out    = poly9_select ? p9[8:1] : p17[16:9];

endmodule

// File: tb/tb_pokey_poly_gen.sv
// Randomized bench for pokey_poly_gen: outputs are predicted from precomputed polynomial
// sequence tables indexed by the number of steps taken since the last clear.
module tb_pokey_poly_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       init;
    logic       poly9_select;
    logic       noise_4;
    logic       noise_5;
    logic       noise_large;
    logic [7:0] rand_out;
    logic       noise_step;

    int tests = 0;
    int fails = 0;

    int unsigned seq4[15];
    int unsigned seq5[31];
    int unsigned seq9[511];
    int unsigned seq17[131071];

    int unsigned steps;
    bit          exp_step;
    bit          compare_on = 1'b0;

    pokey_poly_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .init         (init),
        .poly9_select (poly9_select),
        .noise_4      (noise_4),
        .noise_5      (noise_5),
        .noise_large  (noise_large),
        .rand_out     (rand_out),
        .noise_step   (noise_step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned s, input int width,
                                              input int ta, input int tb);
        int unsigned fb;
        fb = (~((s >> ta) ^ (s >> tb))) & 1;
        return ((s << 1) | fb) & ((32'd1 << width) - 1);
    endfunction

    // Walk a polynomial from zero until it comes back to zero, reporting whether all-ones was seen.
    function automatic int period_of(input int width, input int ta, input int tb,
                                     output bit saw_ones);
        int unsigned s = 0;
        int          cnt = 0;
        saw_ones = 1'b0;
        do begin
            s = lfsr_next(s, width, ta, tb);
            cnt++;
            if (s == ((32'd1 << width) - 1)) saw_ones = 1'b1;
        end while (s != 0 && cnt < 200000);
        return cnt;
    endfunction

    // Model: count of steps since the last reset/init; the register values follow from the tables.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            steps    <= 0;
            exp_step <= 1'b0;
        end else if (init) begin
            steps    <= 0;
            exp_step <= 1'b0;
        end else if (enable) begin
            steps    <= steps + 1;
            exp_step <= 1'b1;
        end else begin
            exp_step <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            int unsigned e4, e5, e9, e17;
            e4  = seq4[steps % 15];
            e5  = seq5[steps % 31];
            e9  = seq9[steps % 511];
            e17 = seq17[steps % 131071];
            check("noise_4",     noise_4,     (e4 >> 3) & 1);
            check("noise_5",     noise_5,     (e5 >> 4) & 1);
            check("noise_large", noise_large, poly9_select ? (e9 >> 8) & 1 : (e17 >> 16) & 1);
            check("rand_out",    rand_out,    poly9_select ? (e9 >> 1) & 8'hFF : (e17 >> 9) & 8'hFF);
            check("noise_step",  noise_step,  exp_step);
        end
    end

    task automatic apply_stimulus(input bit en, input bit in, input bit sel);
        @(posedge clk);
        #2;
        enable       = en;
        init         = in;
        poly9_select = sel;
    endtask

    // Four isolated enable pulses from the cleared state.
    task automatic check_output_pulses();
        logic exp_n4 [4];
        exp_n4 = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, poly9_select);
            apply_stimulus(1'b0, 1'b0, poly9_select);
            @(negedge clk);
            check("pulse_step", noise_step, 1'b1);
            check("pulse_noise_4", noise_4, exp_n4[i]);
        end
    endtask

    initial begin
        bit ones;
        int p;

        reset        = 1'b1;
        enable       = 1'b0;
        init         = 1'b0;
        poly9_select = 1'b0;

        p = period_of(4, 3, 2, ones);   check("period_p4", p, 15);     check("ones_p4", ones, 0);
        p = period_of(5, 4, 2, ones);   check("period_p5", p, 31);     check("ones_p5", ones, 0);
        p = period_of(9, 8, 4, ones);   check("period_p9", p, 511);    check("ones_p9", ones, 0);
        p = period_of(17, 16, 13, ones); check("period_p17", p, 131071); check("ones_p17", ones, 0);

        seq4[0] = 0; seq5[0] = 0; seq9[0] = 0; seq17[0] = 0;
        for (int i = 1; i < 15; i++)     seq4[i]  = lfsr_next(seq4[i-1], 4, 3, 2);
        for (int i = 1; i < 31; i++)     seq5[i]  = lfsr_next(seq5[i-1], 5, 4, 2);
        for (int i = 1; i < 511; i++)    seq9[i]  = lfsr_next(seq9[i-1], 9, 8, 4);
        for (int i = 1; i < 131071; i++) seq17[i] = lfsr_next(seq17[i-1], 17, 16, 13);

        check("seq4_1", seq4[1], 1);
        check("seq4_2", seq4[2], 3);
        check("seq4_3", seq4[3], 7);
        check("seq4_4", seq4[4], 14);
        check("seq5_4", seq5[4], 14);

        #1;
        check("reset_rand", rand_out, 8'h00);
        check("reset_step", noise_step, 1'b0);
        compare_on = 1'b1;

        apply_stimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        check_output_pulses();

        for (int i = 0; i < 2000; i++)
            apply_stimulus(($urandom % 3) != 0, ($urandom % 60) == 0,
                           (($urandom % 16) == 0) ? ~poly9_select : poly9_select);

        // Init held with enable pulsing: nothing moves, then the sequence restarts.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, poly9_select);
            @(negedge clk);
            if (i > 0) begin
                check("init_step", noise_step, 1'b0);
                check("init_noise_4", noise_4, 1'b0);
                check("init_rand", rand_out, 8'h00);
            end
        end
        apply_stimulus(1'b0, 1'b0, poly9_select);
        check_output_pulses();

        // Full 9-bit period with back-to-back enables returns p9 to zero.
        @(posedge clk);
        #2 reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        #1 reset = 1'b0;
        for (int i = 0; i < 511; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("p9_wrap_rand", rand_out, 8'h00);
        check("p9_wrap_large", noise_large, 1'b0);
        check("p9_wrap_steps", steps, 511);

        for (int i = 0; i < 40; i++)
            apply_stimulus(($urandom % 2) == 1, 1'b0, ($urandom % 8) == 0);

        // Asynchronous reset between edges clears outputs before the next edge.
        apply_stimulus(1'b1, 1'b0, poly9_select);
        #1 reset = 1'b1;
        #1;
        check("async_noise_4", noise_4, 1'b0);
        check("async_noise_5", noise_5, 1'b0);
        check("async_large", noise_large, 1'b0);
        check("async_rand", rand_out, 8'h00);
        check("async_step", noise_step, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check_output_pulses();

        apply_stimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        compare_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
